// File: rtl/alu_mul_sequencer.sv
// Iterative 32x32 unsigned shift-and-add multiplier that borrows the datapath ALU
// for its one conditional add per clock; the 64-bit product is ready 33 cycles after start.
module alu_mul_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry
);

  // Handshake: start is a level request that is accepted only on an edge where the
  // sequencer is in IDLE or DONE; it is ignored in RUN. There is no back-pressure:
  // done is a one-cycle valid pulse and the product then stays on product_hi/lo.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] p_hi_q, p_hi_d;
  logic [WIDTH-1:0] p_lo_q, p_lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          m_d     = multiplicand;
          p_lo_d  = multiplier;
          p_hi_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // The ALU carry becomes the new top bit, so the 65-bit partial sum never overflows.
        if (p_lo_q[0]) begin
          {p_hi_d, p_lo_d} = {alu_carry, alu_out, p_lo_q[WIDTH-1:1]};
        end else begin
          {p_hi_d, p_lo_d} = {1'b0, p_hi_q, p_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign product_hi = p_hi_q;
  assign product_lo = p_lo_q;
  assign alu_ctrl   = 3'b000;
  assign alu_a      = p_hi_q;
  assign alu_b      = m_q;

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Iterative 32x32 unsigned shift-and-add multiplier that acts as the initiator on the datapath ALU interface.
- Drives the ALU's control code and both operand buses, and consumes the ALU's result and carry flag. It performs one conditional add per clock.
- Produces a 64-bit product 33 cycles after start.
- Sits beside the datapath ALU and serves a future MUL instruction without adding a second adder.

Parameters:
- WIDTH, 32, operand width. It must equal the ALU data width; only 32 is supported.
- CNT_W, 6, iteration counter width. It must hold the value WIDTH.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiply. Sampled only in IDLE or DONE.
- multiplicand  input  WIDTH  operand M. Captured on the accepted start.
- multiplier  input  WIDTH  operand Q. Captured on the accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse in DONE; product valid.
- product_hi  output  WIDTH  upper half of the product.
- product_lo  output  WIDTH  lower half of the product.
- alu_ctrl  output  3  ALU control code; constant 3'b000 (add).
- alu_a  output  WIDTH  ALU operand A; equals the P_hi register.
- alu_b  output  WIDTH  ALU operand B; equals the M register.
- alu_out  input  WIDTH  ALU sum, combinational from alu_a/alu_b.
- alu_carry  input  1  ALU carry-out of the add.

Behaviour:
- Registers:
  - M[WIDTH], P_hi[WIDTH], P_lo[WIDTH], cnt[CNT_W].
  - state in {IDLE, RUN, DONE}.
- Reset (rst=1 at an edge, any state, including mid-RUN):
  - state=IDLE; M, P_hi, P_lo and cnt all 0.
  - busy=0, done=0, product_hi=0, product_lo=0; alu_ctrl stays 3'b000.
  - Reset has priority over start.
- Outputs:
  - product_hi=P_hi and product_lo=P_lo, registered directly.
  - busy=(state==RUN); done=(state==DONE).
- IDLE:
  - start=1 → M←multiplicand, P_lo←multiplier, P_hi←0, cnt←0, state←RUN.
  - Otherwise hold all registers; the product from the previous operation stays visible.
- RUN, each cycle:
  - If P_lo[0]=1: {P_hi,P_lo} ← {alu_carry, alu_out, P_lo[WIDTH-1:1]}, i.e. a 65-bit {carry,sum,P_lo} shifted right by 1.
  - If P_lo[0]=0: {P_hi,P_lo} ← {1'b0, P_hi, P_lo[WIDTH-1:1]}. The ALU result is ignored.
  - cnt←cnt+1. When cnt==WIDTH-1 at the edge, state←DONE.
  - start is ignored in RUN; operands are not re-captured.
- RUN duration: exactly WIDTH cycles.
- Latency:
  - Start accepted at edge E0; busy is high for edges E0+1 … E0+32.
  - done is high for exactly the one cycle following edge E0+32.
- DONE:
  - done=1 for one cycle; the product is final.
  - start=1 in DONE is accepted exactly as in IDLE (load operands, go to RUN), giving back-to-back operation with no idle gap.
  - Otherwise state←IDLE and the product is held.
- ALU interface:
  - The ALU is purely combinational; alu_out and alu_carry are used in the same cycle alu_a/alu_b are driven.
  - alu_ctrl never changes from 3'b000.
  - The ALU's overflow, sign and zero flags are not used.
- Arithmetic: unsigned only; the carry captured into P_hi[WIDTH-1] guarantees a full 2*WIDTH-bit result with no overflow.
- Operands changing on multiplicand/multiplier after capture have no effect.

Test Plan:
- Basic multiply: rst for 2 cycles, then start with M=3, Q=5 → busy for 32 cycles, then done pulse with {hi,lo}=0x00000000_0000000F. alu_ctrl is 000 throughout.
- Max operands: M=0xFFFFFFFF, Q=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Exercises alu_carry=1 on the adds.
- Zero operand, plus hold: M=0x12345678, Q=0 → product 0, done 33 cycles after start. Then product held at 0 for 10 idle cycles with done=0.
- Ignored start: start with M=7, Q=6. Pulse start at RUN cycle 10 with M=9, Q=9 → result still 0x2A and done timing unchanged.
- Back-to-back: assert start with M=0x10000, Q=0x10000 during the DONE cycle of a prior op → new RUN begins immediately. Result hi=0x00000001, lo=0.
- Reset mid-operation: rst=1 at RUN cycle 15 → next cycle busy=0, done=0, product=0. A subsequent start with M=2, Q=0x80000000 yields hi=1, lo=0.
